dm_store_buffer: RTL and testbench

Posted-store buffer between the MEM pipeline stage and the byte-addressed data memory `dm`. Accepts stores in one cycle, queues them in a small FIFO, and drains one per cycle into `dm` whenever `dm` is not serving a load. Loads that overlap a queued store are either satisfied from the buffer (forwarding) or stalled until the conflicting store has drained, so program-order memory semantics are preserved.

---
 rtl/dm_pkg.sv | 60 ++++++
 rtl/sb_overlap.sv | 30 +++
 rtl/dm_store_buffer.sv | 192 +++++++++++++++++++
 tb/tb_dm_store_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory port and the store buffer in front of it.
//   - dm_type_e : DMType access codes (word / half / half-u / byte / byte-u)
//   - size_of   : access size in bytes for a DMType code
//   - extend    : sign/zero extension of low bytes per DMType code
//   - st_legal  : store-side legality of a DMType code
// -----------------------------------------------------------------------------
package dm_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  // Access size in bytes; unknown codes are treated as a full word so that a
  // malformed load can only over-approximate its footprint (and stall).
  function automatic logic [2:0] size_of(input logic [2:0] t);
    logic [2:0] sz;
    case (t)
      DM_WORD:   sz = 3'd4;
      DM_HALF:   sz = 3'd2;
      DM_HALF_U: sz = 3'd2;
      DM_BYTE:   sz = 3'd1;
      DM_BYTE_U: sz = 3'd1;
      default:   sz = 3'd4;
    endcase
    return sz;
  endfunction

  // Extend the low bytes of d to 32 bits as selected by the access type.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] t);
    logic [31:0] r;
    case (t)
      DM_WORD:   r = d;
      DM_HALF:   r = {{16{d[15]}}, d[15:0]};
      DM_HALF_U: r = {16'h0000, d[15:0]};
      DM_BYTE:   r = {{24{d[7]}}, d[7:0]};
      DM_BYTE_U: r = {24'h000000, d[7:0]};
      default:   r = d;
    endcase
    return r;
  endfunction

  // Stores only come in signed flavours: word, half, byte.
  function automatic logic st_legal(input logic [2:0] t);
    logic ok;
    case (t)
      DM_WORD: ok = 1'b1;
      DM_HALF: ok = 1'b1;
      DM_BYTE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sb_overlap.sv
// -----------------------------------------------------------------------------
// sb_overlap
// Combinational test whether two byte ranges [addr, addr+size) intersect, with
// addresses wrapping modulo 2^AW.
// Ports:
//   a_addr, a_size : first range (size 1..4)
//   b_addr, b_size : second range (size 1..4)
//   hit            : 1 when the ranges share at least one byte
// -----------------------------------------------------------------------------
module sb_overlap #(
  parameter int AW = 6
) (
  input  logic [AW-1:0] a_addr,
  input  logic [2:0]    a_size,
  input  logic [AW-1:0] b_addr,
  input  logic [2:0]    b_size,
  output logic          hit
);

  logic [AW-1:0] d_ba_s;
  logic [AW-1:0] d_ab_s;

  // Modular distances: the ranges intersect iff either start lies inside the
  // other range, which is exactly "distance from its start < its size".
  assign d_ba_s = b_addr - a_addr;
  assign d_ab_s = a_addr - b_addr;

  assign hit = (d_ba_s < AW'(a_size)) || (d_ab_s < AW'(b_size));

endmodule

// File: rtl/dm_store_buffer.sv
// -----------------------------------------------------------------------------
// dm_store_buffer
// Posted-store FIFO between the MEM stage and the data memory dm. Stores are
// accepted in one cycle and drained one per cycle whenever dm is not serving a
// load. Loads overlapping a queued store are forwarded or stalled.
// Optional feature macro: SB_FORWARD_EN (store-to-load forwarding). Without it
// every overlapping load stalls and ld_sel / ld_fwd_data are tied to 0.
// Ports:
//   clk, rstn                      : clock, async active-low reset
//   st_valid/st_ready              : store handshake
//   st_addr/st_data/st_type        : store request
//   st_err                         : one-cycle pulse for an illegal st_type
//   ld_valid/ld_addr/ld_type       : load request
//   ld_stall                       : combinational, load must be re-presented
//   ld_sel                         : registered, 1 = use ld_fwd_data
//   ld_fwd_data                    : registered forwarded load data
//   dm_wr/dm_addr/dm_din/dm_type   : dm port (DMWr/addr/din/DMType)
//   sb_empty                       : buffer holds no stores
// -----------------------------------------------------------------------------
module dm_store_buffer
  import dm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [2:0]    st_type,
  output logic          st_err,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [2:0]    ld_type,
  output logic          ld_stall,
  output logic          ld_sel,
  output logic [31:0]   ld_fwd_data,
  output logic          dm_wr,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic [2:0]    dm_type,
  output logic          sb_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // Entry storage
  logic [AW-1:0] addr_r [DEPTH];
  logic [31:0]   data_r [DEPTH];
  logic [2:0]    type_r [DEPTH];

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          st_err_r;

  logic [2:0]       ld_size_s;
  logic [DEPTH-1:0] hit_s;
  logic             any_hit_s;
  logic             fwd_s;
  logic             ld_port_s;
  logic             drain_s;
  logic             enq_s;

  assign ld_size_s = size_of(ld_type);

  // Per-entry overlap against the presented load, masked by entry occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] age_s;
    logic          ovl_s;

    assign age_s = PW'(i) - head_r;

    sb_overlap #(.AW(AW)) u_ovl (
      .a_addr (addr_r[i]),
      .a_size (size_of(type_r[i])),
      .b_addr (ld_addr),
      .b_size (ld_size_s),
      .hit    (ovl_s)
    );

    assign hit_s[i] = ovl_s && ({1'b0, age_s} < count_r);
  end

  assign any_hit_s = |hit_s;

`ifdef SB_FORWARD_EN
  logic [PW-1:0] y_idx_s;
  logic          y_match_s;
  logic [31:0]   ld_fwd_data_r;
  logic          ld_sel_r;

  // Locate the youngest overlapping entry by walking from head (oldest) forward.
  always_comb begin
    logic [PW-1:0] idx_v;
    idx_v   = '0;
    y_idx_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_v   = head_r + PW'(k);
      y_idx_s = hit_s[idx_v] ? idx_v : y_idx_s;
    end
  end

  // Forwarding is only exact when the youngest store covers the load from the same base byte.
  assign y_match_s = (addr_r[y_idx_s] == ld_addr) &&
                     (size_of(type_r[y_idx_s]) >= ld_size_s);
  assign fwd_s     = ld_valid && any_hit_s && y_match_s;

  // Registered forwarding result, presented the cycle after the load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_sel_r      <= 1'b0;
      ld_fwd_data_r <= 32'h0000_0000;
    end else begin
      ld_sel_r <= fwd_s;
      if (fwd_s) begin
        ld_fwd_data_r <= extend(data_r[y_idx_s], ld_type);
      end
    end
  end

  assign ld_sel      = ld_sel_r;
  assign ld_fwd_data = ld_fwd_data_r;
`else
  assign fwd_s       = 1'b0;
  assign ld_sel      = 1'b0;
  assign ld_fwd_data = 32'h0000_0000;
`endif

  // A load owns the dm port only when no queued store overlaps it.
  assign ld_port_s = ld_valid && !any_hit_s;
  assign ld_stall  = ld_valid && any_hit_s && !fwd_s;
  assign drain_s   = (count_r != CW'(0)) && !ld_port_s;
  assign st_ready  = (count_r != CW'(DEPTH));
  assign enq_s     = st_valid && st_ready && st_legal(st_type);
  assign sb_empty  = (count_r == CW'(0));
  assign st_err    = st_err_r;

  // dm port mux: load read, head drain, or idle.
  always_comb begin
    dm_wr   = 1'b0;
    dm_addr = '0;
    dm_din  = 32'h0000_0000;
    dm_type = DM_WORD;
    if (ld_port_s) begin
      dm_addr = ld_addr;
      dm_type = ld_type;
    end else if (drain_s) begin
      dm_wr   = 1'b1;
      dm_addr = addr_r[head_r];
      dm_din  = data_r[head_r];
      dm_type = type_r[head_r];
    end else begin
      dm_wr   = 1'b0;
    end
  end

  // FIFO pointers, occupancy, entry writes and the illegal-type pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      st_err_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= 32'h0000_0000;
        type_r[i] <= DM_WORD;
      end
    end else begin
      st_err_r <= st_valid && st_ready && !st_legal(st_type);
      if (enq_s) begin
        addr_r[tail_r] <= st_addr;
        data_r[tail_r] <= st_data;
        type_r[tail_r] <= st_type;
        tail_r         <= tail_r + PW'(1);
      end
      if (drain_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({enq_s, drain_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        st_valid;
  logic        st_ready;
  logic [5:0]  st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_type;
  logic        st_err;
  logic        ld_valid;
  logic [5:0]  ld_addr;
  logic [2:0]  ld_type;
  logic        ld_stall;
  logic        ld_sel;
  logic [31:0] ld_fwd_data;
  logic        dm_wr;
  logic [5:0]  dm_addr;
  logic [31:0] dm_din;
  logic [2:0]  dm_type;
  logic        sb_empty;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  dm_store_buffer #(.DEPTH(4), .AW(6)) dut (
    .clk(clk), .rstn(rstn),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_type(st_type), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_type(ld_type),
    .ld_stall(ld_stall), .ld_sel(ld_sel), .ld_fwd_data(ld_fwd_data),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type),
    .sb_empty(sb_empty)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; st_valid = 1'b0; st_addr = 6'h00; st_data = 32'h0; st_type = 3'b000;
    ld_valid = 1'b0; ld_addr = 6'h00; ld_type = 3'b000;
    #2;
    total++; if (sb_empty !== 1'b1) $display("FAIL rst_empty got %0h want 1", sb_empty); else pass_cnt++;
    total++; if (st_ready !== 1'b1) $display("FAIL rst_ready got %0h want 1", st_ready); else pass_cnt++;
    total++; if (dm_wr !== 1'b0) $display("FAIL rst_dm_wr got %0h want 0", dm_wr); else pass_cnt++;
    total++; if (st_err !== 1'b0 || ld_sel !== 1'b0) $display("FAIL rst_err_sel got %0h/%0h want 0/0", st_err, ld_sel); else pass_cnt++;
    total++; if (ld_fwd_data !== 32'h0) $display("FAIL rst_fwd got %0h want 0", ld_fwd_data); else pass_cnt++;
    tick; tick;
    rstn = 1'b1;
    tick;
  endtask

  task automatic test_store_drain;
    st_valid = 1'b1; st_addr = 6'h04; st_data = 32'h1122_3344; st_type = 3'b000;
    #1;
    total++; if (dm_wr !== 1'b0) $display("FAIL sd_accept_wr got %0h want 0", dm_wr); else pass_cnt++;
    tick;
    st_valid = 1'b0;
    #1;
    total++; if (dm_wr !== 1'b1) $display("FAIL sd_wr got %0h want 1", dm_wr); else pass_cnt++;
    total++; if (dm_addr !== 6'h04) $display("FAIL sd_addr got %0h want 04", dm_addr); else pass_cnt++;
    total++; if (dm_din !== 32'h1122_3344) $display("FAIL sd_din got %0h want 11223344", dm_din); else pass_cnt++;
    total++; if (sb_empty !== 1'b0) $display("FAIL sd_nonempty got %0h want 0", sb_empty); else pass_cnt++;
    tick;
    #1;
    total++; if (sb_empty !== 1'b1 || dm_wr !== 1'b0) $display("FAIL sd_after got empty=%0h wr=%0h want 1/0", sb_empty, dm_wr); else pass_cnt++;
  endtask

  task automatic test_fill;
    ld_valid = 1'b1; ld_addr = 6'h30; ld_type = 3'b000;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 6'(i * 8); st_data = 32'hA000_0000 | i; st_type = 3'b000;
      #1;
      total++; if (dm_wr !== 1'b0 || dm_addr !== 6'h30) $display("FAIL fill_ld_port[%0d] got wr=%0h addr=%0h want 0/30", i, dm_wr, dm_addr); else pass_cnt++;
      tick;
    end
    st_addr = 6'h20; st_data = 32'hA000_0004;
    #1;
    total++; if (st_ready !== 1'b0) $display("FAIL fill_full got %0h want 0", st_ready); else pass_cnt++;
    tick;
    total++; if (st_ready !== 1'b0 || dm_wr !== 1'b0) $display("FAIL fill_held got ready=%0h wr=%0h want 0/0", st_ready, dm_wr); else pass_cnt++;
    ld_valid = 1'b0;
    #1;
    total++; if (dm_wr !== 1'b1 || dm_din !== 32'hA000_0000 || dm_addr !== 6'h00) $display("FAIL fill_drain0 got wr=%0h din=%0h addr=%0h want 1/a0000000/00", dm_wr, dm_din, dm_addr); else pass_cnt++;
    total++; if (st_ready !== 1'b0) $display("FAIL fill_no_ready_through got %0h want 0", st_ready); else pass_cnt++;
    tick;
    total++; if (st_ready !== 1'b1 || dm_din !== 32'hA000_0001 || dm_addr !== 6'h08) $display("FAIL fill_drain1 got ready=%0h din=%0h addr=%0h want 1/a0000001/08", st_ready, dm_din, dm_addr); else pass_cnt++;
    tick;
    st_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      #1;
      total++; if (dm_wr !== 1'b1 || dm_din !== (32'hA000_0000 | k)) $display("FAIL fill_drain%0d got wr=%0h din=%0h want 1/%0h", k, dm_wr, dm_din, 32'hA000_0000 | k); else pass_cnt++;
      tick;
    end
    total++; if (sb_empty !== 1'b1 || dm_wr !== 1'b0) $display("FAIL fill_end got empty=%0h wr=%0h want 1/0", sb_empty, dm_wr); else pass_cnt++;
  endtask

  task automatic test_forward(input logic [2:0] lt, input logic [31:0] want);
    logic [31:0] exp_fwd;
    exp_fwd = FWD ? want : 32'h0;
    st_valid = 1'b1; st_addr = 6'h10; st_data = 32'h0000_0080; st_type = 3'b011;
    tick;
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 6'h10; ld_type = lt;
    #1;
    total++; if (ld_stall !== !FWD) $display("FAIL fwd_stall[%0h] got %0h want %0h", lt, ld_stall, !FWD); else pass_cnt++;
    total++; if (dm_wr !== 1'b1 || dm_addr !== 6'h10 || dm_din !== 32'h80 || dm_type !== 3'b011) $display("FAIL fwd_drain[%0h] got wr=%0h addr=%0h din=%0h type=%0h want 1/10/80/3", lt, dm_wr, dm_addr, dm_din, dm_type); else pass_cnt++;
    tick;
    ld_valid = 1'b0;
    #1;
    total++; if (ld_sel !== FWD) $display("FAIL fwd_sel[%0h] got %0h want %0h", lt, ld_sel, FWD); else pass_cnt++;
    total++; if (ld_fwd_data !== exp_fwd) $display("FAIL fwd_data[%0h] got %0h want %0h", lt, ld_fwd_data, exp_fwd); else pass_cnt++;
    tick;
  endtask

  task automatic test_partial_stall;
    st_valid = 1'b1; st_addr = 6'h11; st_data = 32'h0000_0055; st_type = 3'b011;
    tick;
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 6'h10; ld_type = 3'b000;
    #1;
    total++; if (ld_stall !== 1'b1) $display("FAIL ps_stall got %0h want 1", ld_stall); else pass_cnt++;
    total++; if (dm_wr !== 1'b1 || dm_addr !== 6'h11) $display("FAIL ps_drain got wr=%0h addr=%0h want 1/11", dm_wr, dm_addr); else pass_cnt++;
    tick;
    total++; if (ld_stall !== 1'b0 || dm_wr !== 1'b0 || dm_addr !== 6'h10 || dm_type !== 3'b000) $display("FAIL ps_read got stall=%0h wr=%0h addr=%0h type=%0h want 0/0/10/0", ld_stall, dm_wr, dm_addr, dm_type); else pass_cnt++;
    tick;
    ld_valid = 1'b0;
    #1;
    total++; if (ld_sel !== 1'b0) $display("FAIL ps_sel got %0h want 0", ld_sel); else pass_cnt++;
  endtask

  task automatic test_err;
    st_valid = 1'b1; st_addr = 6'h08; st_data = 32'hDEAD_BEEF; st_type = 3'b010;
    #1;
    total++; if (st_err !== 1'b0) $display("FAIL err_early got %0h want 0", st_err); else pass_cnt++;
    tick;
    st_valid = 1'b0; st_type = 3'b000;
    #1;
    total++; if (st_err !== 1'b1 || sb_empty !== 1'b1 || dm_wr !== 1'b0) $display("FAIL err_pulse got err=%0h empty=%0h wr=%0h want 1/1/0", st_err, sb_empty, dm_wr); else pass_cnt++;
    tick;
    total++; if (st_err !== 1'b0) $display("FAIL err_clear got %0h want 0", st_err); else pass_cnt++;
  endtask

  task automatic test_reset_midflight;
    ld_valid = 1'b1; ld_addr = 6'h30; ld_type = 3'b000;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 6'(i * 4); st_data = 32'hC000_0000 | i; st_type = 3'b000;
      tick;
    end
    st_valid = 1'b0;
    #1;
    total++; if (sb_empty !== 1'b0) $display("FAIL rm_loaded got %0h want 0", sb_empty); else pass_cnt++;
    ld_valid = 1'b0;
    rstn = 1'b0;
    #1;
    total++; if (sb_empty !== 1'b1 || st_ready !== 1'b1) $display("FAIL rm_state got empty=%0h ready=%0h want 1/1", sb_empty, st_ready); else pass_cnt++;
    total++; if (dm_wr !== 1'b0 || dm_addr !== 6'h00 || dm_din !== 32'h0 || dm_type !== 3'b000) $display("FAIL rm_port got wr=%0h addr=%0h din=%0h type=%0h want 0/0/0/0", dm_wr, dm_addr, dm_din, dm_type); else pass_cnt++;
    total++; if (st_err !== 1'b0 || ld_sel !== 1'b0 || ld_fwd_data !== 32'h0) $display("FAIL rm_regs got err=%0h sel=%0h fwd=%0h want 0/0/0", st_err, ld_sel, ld_fwd_data); else pass_cnt++;
    tick;
    rstn = 1'b1;
    tick;
    total++; if (dm_wr !== 1'b0 || sb_empty !== 1'b1) $display("FAIL rm_discard got wr=%0h empty=%0h want 0/1", dm_wr, sb_empty); else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [31:0] exp_fwd;
    st_valid = 1'b1; st_addr = 6'h3F; st_data = 32'h0000_BEEF; st_type = 3'b001;
    tick;
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 6'h00; ld_type = 3'b011;
    #1;
    total++; if (ld_stall !== 1'b1) $display("FAIL wrap_stall got %0h want 1", ld_stall); else pass_cnt++;
    total++; if (dm_wr !== 1'b1 || dm_addr !== 6'h3F || dm_type !== 3'b001 || dm_din !== 32'hBEEF) $display("FAIL wrap_drain got wr=%0h addr=%0h type=%0h din=%0h want 1/3f/1/beef", dm_wr, dm_addr, dm_type, dm_din); else pass_cnt++;
    tick;
    total++; if (ld_stall !== 1'b0 || dm_wr !== 1'b0 || dm_addr !== 6'h00) $display("FAIL wrap_read got stall=%0h wr=%0h addr=%0h want 0/0/00", ld_stall, dm_wr, dm_addr); else pass_cnt++;
    ld_valid = 1'b0;
    tick;
    st_valid = 1'b1; st_addr = 6'h3F; st_data = 32'h0000_BEEF; st_type = 3'b001;
    tick;
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 6'h3F; ld_type = 3'b001;
    #1;
    total++; if (ld_stall !== !FWD) $display("FAIL wrap_same_stall got %0h want %0h", ld_stall, !FWD); else pass_cnt++;
    tick;
    ld_valid = 1'b0;
    exp_fwd = FWD ? 32'hFFFF_BEEF : 32'h0;
    #1;
    total++; if (ld_fwd_data !== exp_fwd || ld_sel !== FWD) $display("FAIL wrap_same_fwd got data=%0h sel=%0h want %0h/%0h", ld_fwd_data, ld_sel, exp_fwd, FWD); else pass_cnt++;
    tick;
  endtask

  initial begin
    test_reset;
    test_store_drain;
    test_fill;
    test_forward(3'b011, 32'hFFFF_FF80);
    test_forward(3'b100, 32'h0000_0080);
    test_partial_stall;
    test_err;
    test_reset_midflight;
    test_wrap;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
